axist_rand_chk: RTL and testbench

Receive-side LFSR pattern checker for the AXI4-ST GPIO examples. It sits downstream of the link, consuming the received data beats that the transmit-side LFSR generator produced. From the same seed it regenerates the expected sequence locally, compares each accepted beat, and counts mismatches. It reports pass/fail, the first failing beat, and a no-traffic timeout to the test controller.

---
 rtl/axist_chk_pkg.sv | 26 ++
 rtl/axist_rand_chk_if.sv | 11 +
 rtl/axist_rand_chk_lfsr.sv | 37 +++
 rtl/axist_rand_chk.sv | 140 ++++++++++++++
 tb/tb_axist_rand_chk.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axist_chk_pkg.sv
// Shared definitions for the AXI4-ST LFSR pattern checker: data-width modes,
// FSM state type and the LFSR step function also used by the generator side.
package axist_chk_pkg;

  localparam int unsigned FULL = 1;
  localparam int unsigned HALF = 2;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDone
  } chk_state_e;

  // Values travel right-aligned in an 80-bit container; FULL uses only [39:0].
  function automatic logic [79:0] lfsr_next(input int unsigned mode, input logic [79:0] value);
    logic fb;
    if (mode == HALF) begin
      fb = value[79] ^ value[78] ^ value[42] ^ value[41];
      return {value[78:0], fb};
    end else begin
      fb = value[39] ^ value[37] ^ value[20] ^ value[18];
      return {40'b0, value[38:0], fb};
    end
  endfunction

endpackage

// File: rtl/axist_rand_chk_if.sv
// Receive-side AXI4-ST beat channel into the pattern checker.
interface axist_rand_chk_if #(
  parameter int unsigned W = 40
) ();
  logic         rx_tvalid;
  logic [W-1:0] rx_tdata;
  logic         rx_tready;

  modport master (output rx_tvalid, output rx_tdata, input rx_tready);
  modport slave  (input rx_tvalid, input rx_tdata, output rx_tready);
endinterface

// File: rtl/axist_rand_chk_lfsr.sv
// Expected-value register: loads the seed, or steps one LFSR position per accepted beat.
module axist_rand_chk_lfsr
  import axist_chk_pkg::*;
#(
  parameter int unsigned Mode = FULL,
  parameter int unsigned W    = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] exp_o
);

  logic [W-1:0] exp_q, exp_d;

  always_comb begin
    exp_d = exp_q;
    if (load_i) begin
      exp_d = seed_i;
    end else if (step_i) begin
      exp_d = W'(lfsr_next(Mode, 80'(exp_q)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_o = exp_q;

endmodule

// File: rtl/axist_rand_chk.sv
// Receive-side LFSR pattern checker: regenerates the transmit sequence from the seed,
// compares each accepted beat, counts mismatches and reports pass/fail/timeout.
module axist_rand_chk
  import axist_chk_pkg::*;
#(
  parameter int unsigned LEADER_MODE = FULL,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned W = (LEADER_MODE == HALF) ? 80 : 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W-1:0]           seed_in,
  input  logic [15:0]            num_beats,
  axist_rand_chk_if.slave        rx,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [15:0]            beat_cnt,
  output logic [15:0]            err_cnt,
  output logic [15:0]            first_err_idx,
  output logic [W-1:0]           first_err_data
);

  chk_state_e   state_q, state_d;
  logic [15:0]  num_q, num_d;
  logic [15:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]  err_cnt_q, err_cnt_d;
  logic [15:0]  first_idx_q, first_idx_d;
  logic [W-1:0] first_data_q, first_data_d;
  logic [15:0]  idle_q, idle_d;
  logic         timeout_q, timeout_d;
  logic         pass_q, pass_d;
  logic         lfsr_load, lfsr_step, accept;
  logic [W-1:0] exp_val;

  axist_rand_chk_lfsr #(
    .Mode (LEADER_MODE),
    .W    (W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .seed_i (seed_in),
    .exp_o  (exp_val)
  );

  // A start in the same cycle as a valid beat discards the beat.
  assign rx.rx_tready = (state_q == StCheck) && !start;
  assign accept       = rx.rx_tvalid && rx.rx_tready;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    beat_cnt_d   = beat_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    idle_d       = idle_q;
    timeout_d    = timeout_q;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;

    if (start) begin
      lfsr_load    = 1'b1;
      num_d        = num_beats;
      beat_cnt_d   = '0;
      err_cnt_d    = '0;
      first_idx_d  = '0;
      first_data_d = '0;
      idle_d       = '0;
      timeout_d    = 1'b0;
      state_d      = (num_beats == 16'd0) ? StDone : StCheck;
    end else begin
      unique case (state_q)
        StCheck: begin
          if (accept) begin
            lfsr_step  = 1'b1;
            beat_cnt_d = beat_cnt_q + 16'd1;
            idle_d     = '0;
            if (rx.rx_tdata != exp_val) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
              if (err_cnt_q == 16'd0) begin
                first_idx_d  = beat_cnt_q;
                first_data_d = rx.rx_tdata;
              end
            end
            if (beat_cnt_q + 16'd1 == num_q) state_d = StDone;
          end else begin
            idle_d = idle_q + 16'd1;
            if (idle_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
              timeout_d = 1'b1;
              state_d   = StDone;
            end
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end

    pass_d = (state_d == StDone) && (err_cnt_d == 16'd0) && !timeout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      num_q        <= '0;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      idle_q       <= '0;
      timeout_q    <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      idle_q       <= idle_d;
      timeout_q    <= timeout_d;
      pass_q       <= pass_d;
    end
  end

  assign busy           = (state_q == StCheck);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_data = first_data_q;

endmodule

// File: tb/tb_axist_rand_chk.sv
// Directed bench for axist_rand_chk: a FULL-width checker with a short timeout and a
// HALF-width checker fed from a local LFSR model.
module tb_axist_rand_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // FULL instance, TIMEOUT_CYC = 16
  logic        start_f = 1'b0;
  logic [39:0] seed_f  = '0;
  logic [15:0] nb_f    = '0;
  logic        busy_f, done_f, pass_f, to_f;
  logic [15:0] beat_f, err_f, idx_f;
  logic [39:0] edata_f;
  axist_rand_chk_if #(.W(40)) rx_f ();

  // HALF instance, TIMEOUT_CYC = 64
  logic        start_h = 1'b0;
  logic [79:0] seed_h  = '0;
  logic [15:0] nb_h    = '0;
  logic        busy_h, done_h, pass_h, to_h;
  logic [15:0] beat_h, err_h, idx_h;
  logic [79:0] edata_h;
  axist_rand_chk_if #(.W(80)) rx_h ();

  axist_rand_chk #(.LEADER_MODE(1), .TIMEOUT_CYC(16)) dut_f (
    .clk            (clk),
    .rst            (rst),
    .start          (start_f),
    .seed_in        (seed_f),
    .num_beats      (nb_f),
    .rx             (rx_f),
    .busy           (busy_f),
    .done           (done_f),
    .pass           (pass_f),
    .timeout        (to_f),
    .beat_cnt       (beat_f),
    .err_cnt        (err_f),
    .first_err_idx  (idx_f),
    .first_err_data (edata_f)
  );

  axist_rand_chk #(.LEADER_MODE(2), .TIMEOUT_CYC(64)) dut_h (
    .clk            (clk),
    .rst            (rst),
    .start          (start_h),
    .seed_in        (seed_h),
    .num_beats      (nb_h),
    .rx             (rx_h),
    .busy           (busy_h),
    .done           (done_h),
    .pass           (pass_h),
    .timeout        (to_h),
    .beat_cnt       (beat_h),
    .err_cnt        (err_h),
    .first_err_idx  (idx_h),
    .first_err_data (edata_h)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent HALF reference step
  function automatic logic [79:0] half_step(input logic [79:0] v);
    return {v[78:0], v[79] ^ v[78] ^ v[42] ^ v[41]};
  endfunction

  task automatic start_full(input logic [39:0] seed, input logic [15:0] nb);
    start_f = 1'b1;
    seed_f  = seed;
    nb_f    = nb;
    step();
    start_f = 1'b0;
  endtask

  task automatic beat_full(input logic [39:0] data);
    rx_f.rx_tvalid = 1'b1;
    rx_f.rx_tdata  = data;
    step();
    rx_f.rx_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [79:0] model;
    rx_f.rx_tvalid = 1'b0;
    rx_f.rx_tdata  = '0;
    rx_h.rx_tvalid = 1'b0;
    rx_h.rx_tdata  = '0;

    // Reset state
    #2;
    check("rst_busy", 80'(busy_f), 80'd0);
    check("rst_done", 80'(done_f), 80'd0);
    check("rst_pass", 80'(pass_f), 80'd0);
    check("rst_tready", 80'(rx_f.rx_tready), 80'd0);
    check("rst_beat", 80'(beat_f), 80'd0);
    step();
    rst = 1'b0;
    step();

    // FULL seed 1: beats 1, 2, 4 back-to-back
    start_full(40'h1, 16'd3);
    check("t1_busy", 80'(busy_f), 80'd1);
    rx_f.rx_tvalid = 1'b1;
    rx_f.rx_tdata  = 40'h1;
    step();
    check("t1_beat_lat", 80'(beat_f), 80'd1);
    rx_f.rx_tdata = 40'h2;
    step();
    check("t1_not_done", 80'(done_f), 80'd0);
    rx_f.rx_tdata = 40'h4;
    step();
    rx_f.rx_tvalid = 1'b0;
    check("t1_done", 80'(done_f), 80'd1);
    check("t1_pass", 80'(pass_f), 80'd1);
    check("t1_beat", 80'(beat_f), 80'd3);
    check("t1_err", 80'(err_f), 80'd0);
    check("t1_busy_low", 80'(busy_f), 80'd0);

    // FULL feedback bit: 80_0000_0000 -> 1
    start_full(40'h80_0000_0000, 16'd2);
    beat_full(40'h80_0000_0000);
    beat_full(40'h1);
    check("t2_pass", 80'(pass_f), 80'd1);
    check("t2_done", 80'(done_f), 80'd1);

    // Same run, second beat wrong
    start_full(40'h80_0000_0000, 16'd2);
    beat_full(40'h80_0000_0000);
    beat_full(40'h3);
    check("t3_err", 80'(err_f), 80'd1);
    check("t3_idx", 80'(idx_f), 80'd1);
    check("t3_data", 80'(edata_f), 80'h3);
    check("t3_pass", 80'(pass_f), 80'd0);
    check("t3_done", 80'(done_f), 80'd1);

    // Timeout: 2 of 5 beats, then silence
    start_full(40'h1, 16'd5);
    beat_full(40'h1);
    beat_full(40'h2);
    for (int i = 1; i < 16; i++) step();
    check("t4_no_early_to", 80'(done_f), 80'd0);
    step();
    check("t4_done", 80'(done_f), 80'd1);
    check("t4_timeout", 80'(to_f), 80'd1);
    check("t4_pass", 80'(pass_f), 80'd0);
    check("t4_beat", 80'(beat_f), 80'd2);

    // Start during CHECK with a valid beat: beat discarded, exp reloaded
    start_full(40'h1, 16'd3);
    beat_full(40'h1);
    start_f        = 1'b1;
    seed_f         = 40'h80_0000_0000;
    nb_f           = 16'd2;
    rx_f.rx_tvalid = 1'b1;
    rx_f.rx_tdata  = 40'h1;
    #1;
    check("t5_tready_start", 80'(rx_f.rx_tready), 80'd0);
    step();
    start_f        = 1'b0;
    rx_f.rx_tvalid = 1'b0;
    check("t5_beat_clr", 80'(beat_f), 80'd0);
    check("t5_err_clr", 80'(err_f), 80'd0);
    check("t5_busy", 80'(busy_f), 80'd1);
    beat_full(40'h80_0000_0000);
    beat_full(40'h1);
    check("t5_pass", 80'(pass_f), 80'd1);
    check("t5_beat", 80'(beat_f), 80'd2);

    // Reset mid-run
    start_full(40'h1, 16'd5);
    beat_full(40'h7);
    check("t6_err_pre", 80'(err_f), 80'd1);
    rst = 1'b1;
    #1;
    check("t6_busy", 80'(busy_f), 80'd0);
    check("t6_done", 80'(done_f), 80'd0);
    check("t6_beat", 80'(beat_f), 80'd0);
    check("t6_err", 80'(err_f), 80'd0);
    check("t6_idx", 80'(idx_f), 80'd0);
    check("t6_data", 80'(edata_f), 80'd0);
    check("t6_tready", 80'(rx_f.rx_tready), 80'd0);
    step();
    rst = 1'b0;
    step();
    check("t6_idle_hold", 80'(busy_f), 80'd0);

    // num_beats 0: straight to DONE
    start_f = 1'b1;
    nb_f    = 16'd0;
    seed_f  = 40'h1;
    #1;
    check("t7_tready_start", 80'(rx_f.rx_tready), 80'd0);
    step();
    start_f = 1'b0;
    check("t7_done", 80'(done_f), 80'd1);
    check("t7_pass", 80'(pass_f), 80'd1);
    check("t7_busy", 80'(busy_f), 80'd0);
    rx_f.rx_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_tready", 80'(rx_f.rx_tready), 80'd0);
    end
    rx_f.rx_tvalid = 1'b0;

    // HALF: 1000 model-driven beats with random gaps
    model   = {16'($urandom), $urandom, $urandom} | 80'h1;
    start_h = 1'b1;
    seed_h  = model;
    nb_h    = 16'd1000;
    step();
    start_h = 1'b0;
    for (int b = 0; b < 1000; b++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      rx_h.rx_tvalid = 1'b1;
      rx_h.rx_tdata  = model;
      step();
      rx_h.rx_tvalid = 1'b0;
      model = half_step(model);
    end
    check("t8_done", 80'(done_h), 80'd1);
    check("t8_pass", 80'(pass_h), 80'd1);
    check("t8_beat", 80'(beat_h), 80'd1000);
    check("t8_err", 80'(err_h), 80'd0);
    check("t8_timeout", 80'(to_h), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
